// File: rtl/ex_div_ctrl_pkg.sv
// Shared widths, constants and state encodings for the EX-stage divider controller.
// Kept alongside the ex_div state encodings so both sides of the handshake agree.
package ex_div_ctrl_pkg;

  localparam int unsigned REGS_DATA_BUS        = 32;
  localparam int unsigned DOUBLE_REGS_DATA_BUS = 64;

  localparam logic ENABLE = 1'b1;
  localparam logic TRUE   = 1'b1;
  localparam logic FALSE  = 1'b0;

  localparam logic [REGS_DATA_BUS-1:0] ZERO_WORD = '0;

  localparam int unsigned DRAIN_CNT_W = 2;

  // Drain lengths after a flush: WAIT needs two idle-start cycles, DONE needs one.
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_FROM_WAIT = 2'd2;
  localparam logic [DRAIN_CNT_W-1:0] DRAIN_FROM_DONE = 2'd1;

  // ex_div internal states.
  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  // Controller states.
  typedef enum logic [1:0] {
    DIVCTRL_IDLE  = 2'b00,
    DIVCTRL_WAIT  = 2'b01,
    DIVCTRL_DONE  = 2'b10,
    DIVCTRL_DRAIN = 2'b11
  } divctrl_state_e;

endpackage

// File: rtl/ex_div_ctrl.sv
// EX-stage initiator for the iterative divider: issues start/annul, stalls the pipe,
// returns remainder/quotient for HI/LO writeback and drains the divider after a flush.
module ex_div_ctrl
  import ex_div_ctrl_pkg::*;
(
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            is_div_op,
  input  logic                            is_signed_op,
  input  logic [REGS_DATA_BUS-1:0]        operand1,
  input  logic [REGS_DATA_BUS-1:0]        operand2,
  input  logic                            flush,
  input  logic                            is_stalled,
  input  logic                            div_is_ended,
  input  logic [DOUBLE_REGS_DATA_BUS-1:0] div_result,
  output logic                            div_start,
  output logic                            div_annul,
  output logic                            div_signed,
  output logic [REGS_DATA_BUS-1:0]        div_operand1,
  output logic [REGS_DATA_BUS-1:0]        div_operand2,
  output logic                            stall_request,
  output logic                            hilo_write_enable,
  output logic [REGS_DATA_BUS-1:0]        hi_data,
  output logic [REGS_DATA_BUS-1:0]        lo_data
);

  divctrl_state_e          state_q, state_d;
  logic [DRAIN_CNT_W-1:0]  cnt_q, cnt_d;
  logic                    start_d;
  logic                    signed_d;
  logic [REGS_DATA_BUS-1:0] op1_d, op2_d;
  logic [REGS_DATA_BUS-1:0] hi_d, lo_d;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= DIVCTRL_IDLE;
      cnt_q        <= '0;
      div_start    <= FALSE;
      div_signed   <= FALSE;
      div_operand1 <= ZERO_WORD;
      div_operand2 <= ZERO_WORD;
      hi_data      <= ZERO_WORD;
      lo_data      <= ZERO_WORD;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      div_start    <= start_d;
      div_signed   <= signed_d;
      div_operand1 <= op1_d;
      div_operand2 <= op2_d;
      hi_data      <= hi_d;
      lo_data      <= lo_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    start_d           = div_start;
    signed_d          = div_signed;
    op1_d             = div_operand1;
    op2_d             = div_operand2;
    hi_d              = hi_data;
    lo_d              = lo_data;
    div_annul         = FALSE;
    hilo_write_enable = FALSE;
    stall_request     = FALSE;

    unique case (state_q)
      DIVCTRL_IDLE: begin
        stall_request = is_div_op && !flush;
        start_d       = FALSE;
        if (is_div_op && !flush) begin
          op1_d    = operand1;
          op2_d    = operand2;
          signed_d = is_signed_op;
          start_d  = ENABLE;
          state_d  = DIVCTRL_WAIT;
        end
      end

      // Operands and sign stay frozen: the divider re-reads them in its final correction.
      DIVCTRL_WAIT: begin
        stall_request = !flush;
        if (flush) begin
          div_annul = ENABLE;
          start_d   = FALSE;
          cnt_d     = DRAIN_FROM_WAIT;
          state_d   = DIVCTRL_DRAIN;
        end else if (div_is_ended) begin
          hi_d    = div_result[DOUBLE_REGS_DATA_BUS-1:REGS_DATA_BUS];
          lo_d    = div_result[REGS_DATA_BUS-1:0];
          start_d = FALSE;
          state_d = DIVCTRL_DONE;
        end
      end

      DIVCTRL_DONE: begin
        hilo_write_enable = !flush;
        if (flush) begin
          cnt_d   = DRAIN_FROM_DONE;
          state_d = DIVCTRL_DRAIN;
        end else if (!is_stalled) begin
          state_d = DIVCTRL_IDLE;
        end
      end

      // Holds start low long enough for the divider to fall back to FREE.
      DIVCTRL_DRAIN: begin
        stall_request = is_div_op && !flush;
        start_d       = FALSE;
        if (cnt_q <= 2'd1) begin
          cnt_d   = '0;
          state_d = DIVCTRL_IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = DIVCTRL_IDLE;
      end
    endcase
  end

endmodule
